// File: rtl/ppi_scan_pkg.sv
// Shared types and constants for the PPI key-matrix scanner.
package ppi_scan_pkg;

  localparam int ROW_W = 4;
  localparam logic [7:0] KEY_RELEASED = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    UPDATE,
    GAP
  } scan_state_t;

endpackage

// File: rtl/ppi_key_snapshot.sv
// Per-row storage for the key scanner: previous raw sample and debounced value,
// plus the registered PPI read port with write-through bypass.
module ppi_key_snapshot
  import ppi_scan_pkg::*;
#(
  parameter int ROWS = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ROW_W-1:0] upd_row,
  input  logic             upd_en,
  input  logic             deb_en,
  input  logic [7:0]       upd_data,
  output logic [7:0]       prev_q,
  output logic [7:0]       deb_q,
  input  logic [ROW_W-1:0] rd_row,
  output logic [7:0]       rd_data
);

  logic [7:0] raw_prev  [ROWS];
  logic [7:0] debounced [ROWS];
  logic [7:0] rd_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        raw_prev[i]  <= KEY_RELEASED;
        debounced[i] <= KEY_RELEASED;
      end
    end else begin
      if (upd_en) raw_prev[upd_row]  <= upd_data;
      if (deb_en) debounced[upd_row] <= upd_data;
    end
  end

  always_comb begin
    prev_q = raw_prev[upd_row];
    deb_q  = debounced[upd_row];
  end

  // A debounced write to the row being read this cycle is forwarded so the
  // PPI never sees the stale value.
  always_comb begin
    rd_next = KEY_RELEASED;
    if (int'(rd_row) < ROWS) begin
      if (deb_en && (upd_row == rd_row)) rd_next = upd_data;
      else                               rd_next = debounced[rd_row];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= KEY_RELEASED;
    else       rd_data <= rd_next;
  end

endmodule

// File: rtl/ppi_key_scanner.sv
// Autonomous MSX key-matrix scanner: walks rows, debounces over two frames,
// serves PPI row reads from a snapshot and emits handshaked change events.
module ppi_key_scanner
  import ppi_scan_pkg::*;
#(
  parameter int ROWS          = 11,
  parameter int SETTLE_CYCLES = 24,
  parameter int FRAME_GAP     = 2048
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_enable,
  output logic [ROW_W-1:0] scan_row,
  input  logic [7:0]       scan_column,
  input  logic [ROW_W-1:0] key_matrix_row,
  output logic [7:0]       key_matrix_column,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [ROW_W-1:0] event_row,
  output logic [7:0]       event_data,
  output logic             frame_done
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  scan_state_t      state, state_d;
  logic [ROW_W-1:0] row, row_d;
  logic [SET_W-1:0] settle_cnt, settle_d;
  logic [GAP_W-1:0] gap_cnt, gap_d;
  logic [7:0]       sample, sample_d;
  logic [7:0]       prev_q, deb_q;
  logic             change, slot_free;
  logic             upd_en, deb_en, ev_load, frame_end;

  ppi_key_snapshot #(.ROWS(ROWS)) u_snapshot (
    .clk      (clk),
    .reset    (reset),
    .upd_row  (row),
    .upd_en   (upd_en),
    .deb_en   (deb_en),
    .upd_data (sample),
    .prev_q   (prev_q),
    .deb_q    (deb_q),
    .rd_row   (key_matrix_row),
    .rd_data  (key_matrix_column)
  );

  assign scan_row = row;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      row        <= '0;
      settle_cnt <= '0;
      gap_cnt    <= '0;
      sample     <= KEY_RELEASED;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      row        <= row_d;
      settle_cnt <= settle_d;
      gap_cnt    <= gap_d;
      sample     <= sample_d;
      frame_done <= frame_end;
    end
  end

  always_comb begin
    state_d   = state;
    row_d     = row;
    settle_d  = settle_cnt;
    gap_d     = gap_cnt;
    sample_d  = sample;
    upd_en    = 1'b0;
    deb_en    = 1'b0;
    ev_load   = 1'b0;
    frame_end = 1'b0;
    change    = (sample == prev_q) && (sample != deb_q);
    slot_free = !event_valid || event_ready;

    case (state)
      IDLE: begin
        if (scan_enable) begin
          row_d    = '0;
          settle_d = SET_W'(SETTLE_CYCLES - 1);
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_cnt == '0) state_d = SAMPLE;
        else                  settle_d = settle_cnt - SET_W'(1);
      end
      SAMPLE: begin
        sample_d = scan_column;
        state_d  = UPDATE;
      end
      UPDATE: begin
        // Stall here (no array writes) until the event slot can take a new event.
        if (!(change && !slot_free)) begin
          upd_en   = 1'b1;
          deb_en   = change;
          ev_load  = change;
          settle_d = SET_W'(SETTLE_CYCLES - 1);
          if (row == LAST_ROW) begin
            frame_end = 1'b1;
            if (!scan_enable) begin
              state_d = IDLE;
            end else if (FRAME_GAP == 0) begin
              row_d   = '0;
              state_d = DRIVE;
            end else begin
              gap_d   = GAP_W'(FRAME_GAP - 1);
              state_d = GAP;
            end
          end else if (!scan_enable) begin
            state_d = IDLE;
          end else begin
            row_d   = row + ROW_W'(1);
            state_d = DRIVE;
          end
        end
      end
      GAP: begin
        if (!scan_enable) begin
          state_d = IDLE;
        end else if (gap_cnt == '0) begin
          row_d    = '0;
          settle_d = SET_W'(SETTLE_CYCLES - 1);
          state_d  = DRIVE;
        end else begin
          gap_d = gap_cnt - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_valid <= 1'b0;
      event_row   <= '0;
      event_data  <= KEY_RELEASED;
    end else if (ev_load) begin
      event_valid <= 1'b1;
      event_row   <= row;
      event_data  <= sample;
    end else if (event_ready) begin
      event_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ppi_key_scanner.sv
// Self-checking bench for ppi_key_scanner with a row-addressed matrix model
// and an event scoreboard.
module tb_ppi_key_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_enable;
  logic [3:0] scan_row;
  logic [7:0] scan_column;
  logic [3:0] key_matrix_row;
  logic [7:0] key_matrix_column;
  logic       event_valid;
  logic       event_ready;
  logic [3:0] event_row;
  logic [7:0] event_data;
  logic       frame_done;

  logic [7:0] matrix [16];

  always #5 clk = ~clk;

  always_comb scan_column = matrix[scan_row];

  ppi_key_scanner #(.ROWS(11), .SETTLE_CYCLES(24), .FRAME_GAP(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .scan_enable       (scan_enable),
    .scan_row          (scan_row),
    .scan_column       (scan_column),
    .key_matrix_row    (key_matrix_row),
    .key_matrix_column (key_matrix_column),
    .event_valid       (event_valid),
    .event_ready       (event_ready),
    .event_row         (event_row),
    .event_data        (event_data),
    .frame_done        (frame_done)
  );

  typedef struct packed {
    logic [3:0] row;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [3:0] row;
    logic [7:0] after_stall;
    logic [7:0] after_reset;
  } rd_vec_t;

  ev_t     exp_q[$];
  ev_t     obs_q[$];
  int      obs_rd;
  rd_vec_t vecs [16];
  int      checks;
  int      errors;

  // Accepted events are recorded on the falling edge before the accepting posedge.
  always @(negedge clk)
    if (!reset && event_valid && event_ready) obs_q.push_back({event_row, event_data});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 2000);
    chk(name, frame_done, 1);
  endtask

  task automatic wait_row(input logic [3:0] r, input string name);
    int n = 0;
    while (scan_row !== r && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, scan_row, r);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (event_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, event_valid, 1);
  endtask

  task automatic drain(input string name);
    ev_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin
        chk({name, " event row"}, obs_q[obs_rd].row, e.row);
        chk({name, " event data"}, obs_q[obs_rd].data, e.data);
        obs_rd++;
      end else begin
        chk({name, " missing event"}, obs_q.size(), obs_rd + 1);
      end
    end
    chk({name, " extra events"}, obs_q.size(), obs_rd);
  endtask

  task automatic read_row(input logic [3:0] r, output logic [7:0] v);
    drive_edge();
    key_matrix_row = r;
    @(posedge clk);
    @(negedge clk);
    v = key_matrix_column;
  endtask

  initial begin
    int         cnt [16];
    int         n;
    int         bad;
    logic [7:0] v;

    for (int i = 0; i < 16; i++) begin
      matrix[i]            = 8'hFF;
      cnt[i]               = 0;
      vecs[i].row          = 4'(i);
      vecs[i].after_stall  = 8'hFF;
      vecs[i].after_reset  = 8'hFF;
    end
    vecs[1].after_stall = 8'hFD;
    vecs[2].after_stall = 8'hFB;
    vecs[8].after_stall = 8'hFE;

    checks = 0;
    errors = 0;
    obs_rd = 0;
    reset = 1'b1;
    scan_enable = 1'b0;
    event_ready = 1'b1;
    key_matrix_row = 4'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset scan_row", scan_row, 0);
    chk("reset key_matrix_column", key_matrix_column, 8'hFF);
    chk("reset event_valid", event_valid, 0);
    chk("reset event_row", event_row, 0);
    chk("reset event_data", event_data, 8'hFF);
    chk("reset frame_done", frame_done, 0);

    // All keys released: row dwell, frame period, no events
    drive_edge();
    reset = 1'b0;
    scan_enable = 1'b1;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (frame_done) break;
      cnt[scan_row]++;
    end
    chk("frame1 done", frame_done, 1);
    for (int r = 1; r <= 10; r++) chk($sformatf("dwell row %0d", r), cnt[r], 26);
    @(negedge clk);
    chk("frame_done width", frame_done, 0);
    n = 1;
    while (frame_done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("frame period", n, 350);
    chk("idle matrix events", obs_q.size(), 0);
    for (int i = 0; i < 16; i++) begin
      read_row(vecs[i].row, v);
      chk($sformatf("initial read row %0d", i), v, vecs[i].after_reset);
    end

    // Row 8 held pressed: accepted after the second identical frame
    wait_frame("t2 sync");
    matrix[8] = 8'hFE;
    exp_q.push_back({4'd8, 8'hFE});
    wait_frame("t2 frame A");
    chk("t2 no event after one frame", obs_q.size(), obs_rd);
    wait_frame("t2 frame B");
    drain("t2");
    read_row(4'd8, v);
    chk("t2 read row 8", v, 8'hFE);

    // One-frame glitch on row 3 is rejected
    wait_frame("t3 sync");
    matrix[3] = 8'h7F;
    wait_frame("t3 glitch frame");
    matrix[3] = 8'hFF;
    wait_frame("t3 frame 2");
    wait_frame("t3 frame 3");
    chk("t3 glitch events", obs_q.size(), obs_rd);
    read_row(4'd3, v);
    chk("t3 read row 3", v, 8'hFF);

    // Back-pressure: row 1 event held, scan stalls on row 2
    wait_frame("t4 sync");
    drive_edge();
    event_ready = 1'b0;
    matrix[1] = 8'hFD;
    matrix[2] = 8'hFB;
    exp_q.push_back({4'd1, 8'hFD});
    exp_q.push_back({4'd2, 8'hFB});
    wait_frame("t4 frame E");
    wait_valid("t4 event raised");
    wait_row(4'd2, "t4 reach row 2");
    tick(60);
    chk("t4 stalled scan_row", scan_row, 2);
    chk("t4 held event_valid", event_valid, 1);
    chk("t4 held event_row", event_row, 1);
    chk("t4 held event_data", event_data, 8'hFD);
    drive_edge();
    event_ready = 1'b1;
    tick(5);
    drain("t4");
    wait_frame("t4 resume");
    for (int i = 0; i < 16; i++) begin
      read_row(vecs[i].row, v);
      chk($sformatf("t4 read row %0d", i), v, vecs[i].after_stall);
    end

    // scan_enable dropped mid-DRIVE of row 5: row 5 still commits, then parks
    wait_frame("t5 sync");
    matrix[5] = 8'hDF;
    wait_frame("t5 prime frame");
    exp_q.push_back({4'd5, 8'hDF});
    wait_row(4'd5, "t5 reach row 5");
    tick(5);
    drive_edge();
    scan_enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (scan_row !== 4'd5) bad++;
    end
    chk("t5 scan_row parked cycles off row 5", bad, 0);
    drain("t5");

    // Reset during a stall drops the pending event and restarts the scan
    drive_edge();
    event_ready = 1'b0;
    matrix[4] = 8'hEF;
    matrix[6] = 8'hBF;
    scan_enable = 1'b1;
    wait_frame("t6 frame H");
    wait_valid("t6 event raised");
    wait_row(4'd6, "t6 reach row 6");
    tick(60);
    chk("t6 stalled scan_row", scan_row, 6);
    chk("t6 held event_row", event_row, 4);
    #2;
    reset = 1'b1;
    #1;
    chk("t6 async event_valid", event_valid, 0);
    chk("t6 async scan_row", scan_row, 0);
    chk("t6 async key_matrix_column", key_matrix_column, 8'hFF);
    for (int i = 0; i < 16; i++) matrix[i] = 8'hFF;
    event_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t6 restart row", scan_row, 0);
    wait_row(4'd1, "t6 scan advances");
    for (int i = 0; i < 16; i++) begin
      read_row(vecs[i].row, v);
      chk($sformatf("t6 read row %0d", i), v, vecs[i].after_reset);
    end
    chk("t6 events after reset", obs_q.size(), obs_rd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppi_key_scanner.md
Name: ppi_key_scanner

Overview:
- Sequences the physical MSX key matrix on behalf of ip_ppi_mirror.
- Walks every row autonomously, debounces the sampled column bits, and holds a per-row snapshot.
- Serves the PPI's requested row (key_matrix_row) from that snapshot, so PPI reads never wait on matrix settling.
- Emits a handshaked change event per debounced row change, for the host-side keyboard firmware.

Parameters:
ROWS, 11, number of matrix rows scanned (0..ROWS-1), 1..16
SETTLE_CYCLES, 24, clk cycles between driving scan_row and sampling scan_column, >=1
FRAME_GAP, 2048, idle clk cycles between the end of one full scan frame and the next, >=0

Ports:
clk  input  1  system clock (21.477 MHz)
reset  input  1  asynchronous, active-high reset
scan_enable  input  1  1 = scanning runs; 0 = scanner finishes current row then parks in IDLE
scan_row  output  4  row select driven to the physical matrix decoder
scan_column  input  8  raw column bits from the matrix, active-low (0 = pressed)
key_matrix_row  input  4  row requested by ip_ppi_mirror (Port C[3:0])
key_matrix_column  output  8  debounced column for key_matrix_row, to ip_ppi_mirror
event_valid  output  1  change event pending
event_ready  input  1  consumer accepts event when event_valid & event_ready at posedge
event_row  output  4  row whose debounced value changed
event_data  output  8  new debounced value of event_row
frame_done  output  1  1-cycle pulse after the last row of each frame is committed

Behaviour:
- Reset values: scan_row=0, key_matrix_column=8'hFF, event_valid=0, event_row=0, event_data=8'hFF, frame_done=0. All snapshot entries = 8'hFF. All previous-sample entries = 8'hFF. FSM = IDLE, counters = 0.
- Reset is asynchronous and may assert mid-operation. The FSM returns to IDLE and any pending event is dropped.
- Storage: two ROWS x 8 arrays (raw_prev, debounced), register-based.
- PPI read path: key_matrix_column is registered, one-cycle latency from key_matrix_row. Result is debounced[key_matrix_row] if key_matrix_row < ROWS, else 8'hFF.
- Write/read collision: if UPDATE writes the row being read in the same cycle, the read returns the new value (write-through bypass).
- FSM states:
  - IDLE: wait for scan_enable=1; then row=0 -> DRIVE.
  - DRIVE: scan_row=row; settle counter loads SETTLE_CYCLES-1 and counts down; at 0 -> SAMPLE.
  - SAMPLE: capture scan_column into sample register -> UPDATE.
  - UPDATE: debounce rule applies here.
    - If sample == raw_prev[row] and sample != debounced[row]: debounced[row] <= sample and a change event is raised.
    - raw_prev[row] <= sample always.
    - If an event is raised while event_valid=1 and the pending event is not being accepted this cycle, stay in UPDATE (stall) without re-writing. The event is loaded in the cycle the slot frees.
    - After commit: if row == ROWS-1 -> GAP with frame_done pulse, else row+1 -> DRIVE. If scan_enable=0 at commit -> IDLE instead.
  - GAP: count FRAME_GAP cycles (0 = zero extra cycles), then row=0 -> DRIVE. Return to IDLE if scan_enable=0.
- Debounce outcome: a key state is accepted only after two consecutive identical frame samples. Worst-case accept latency is 2 frames.
- Event slot: one entry. event_valid rises the cycle after UPDATE raises an event. It clears on accept. A simultaneous accept and new event reloads the slot with no bubble.
- scan_row holds its value in IDLE and GAP.
- Frame period with no stalls = ROWS*(SETTLE_CYCLES+2) + FRAME_GAP cycles. Default: 11*26 + 2048 = 2334.

Decomposition:
- Package ppi_scan_pkg holds:
  - scan FSM state enum (IDLE, DRIVE, SAMPLE, UPDATE, GAP)
  - the ROW_W=4 constant
  - the KEY_RELEASED=8'hFF constant
- Sub-module ppi_key_snapshot: the dual ROWS x 8 arrays with the registered read port and bypass. The FSM stays in the top module.

Test Plan:
- Reset, then scan_enable=1, scan_column=8'hFF throughout -> scan_row steps 0..10, each held 26 cycles; frame_done pulses once per frame; event_valid never rises; key_matrix_column=8'hFF for rows 0..15.
- Matrix model returns 8'hFE on row 8 only, event_ready=1 -> no change after frame 1; after frame 2 exactly one event (row 8, data 8'hFE); key_matrix_row=8 reads 8'hFE one cycle later.
- Single-frame glitch: row 3 = 8'h7F for one frame only -> no event, debounced row 3 stays 8'hFF.
- event_ready=0, rows 1 and 2 both change -> event (row 1) held; FSM stalls in UPDATE at row 2 and scan_row stays 2; releasing event_ready delivers row 1 then row 2, then scanning resumes.
- key_matrix_row=12 -> key_matrix_column=8'hFF; scan_enable dropped mid-DRIVE of row 5 -> row 5 completes, FSM enters IDLE, scan_row stays 5.
- Reset asserted during a stall with event_valid=1 -> event_valid=0 asynchronously; all rows read 8'hFF; the scan restarts from row 0.
